object_rasterizer: RTL and testbench
====================================

# object_rasterizer

Pixel-generation stage directly downstream of the draw sequencer. It consumes the sequencer's object-select code and erase flag and sweeps the selected sprite's bounding box, or the whole 160×120 screen, one pixel per clock. It emits VGA adapter coordinates and colour, and returns the `doneDrawing` and `doneErasing` handshakes that advance the sequencer. The top level plots when the sequencer's `vgaPlot` and this block's `pixelValid` are both high.

## Interface
Parameters:
- `SCREEN_W`, 160: screen width in pixels.
- `SCREEN_H`, 120: screen height in pixels.
- `PLAYER_W`, `PLAYER_H`, 8 / 6: player sprite size.
- `ENEMY_W`, `ENEMY_H`, 10 / 8: enemy sprite size.
- `BULLET_W`, `BULLET_H`, 2 / 4: bullet sprite size.

Ports:
- `clk`, in, 1: single clock.
- `resetn`, in, 1: reset, synchronous, active-low.
- `objectToDraw`, in, 4: 0 none, 1 player, 2–5 enemy1–4, 6 bullet.
- `inEraseState`, in, 1: full-screen erase request.
- `playerX` / `playerY`, in, 8 / 7: player top-left corner.
- `bulletX` / `bulletY`, in, 8 / 7: bullet top-left corner.
- `enemyX`, in, 32: four 8-bit X values; enemy *n* is at bits [8n-1 : 8n-8].
- `enemyY`, in, 28: four 7-bit Y values; enemy *n* is at bits [7n-1 : 7n-7].
- `enemyAlive`, in, 4: bit *n*-1 marks enemy *n* alive.
- `vgaX`, out, 8: pixel X.
- `vgaY`, out, 7: pixel Y.
- `vgaColour`, out, 3: pixel colour.
- `pixelValid`, out, 1: current outputs are a pixel to plot.
- `doneDrawing`, out, 1: one-cycle pulse at the end of a sprite sweep.
- `doneErasing`, out, 1: one-cycle pulse at the end of an erase sweep.

## Operation
- The state machine has four states: IDLE, ERASE, DRAW, HOLD.
- IDLE:
  - `inEraseState`=1 → ERASE. Erase has priority over any code that arrives in the same cycle.
  - Else code 1–6 → DRAW. Latch base X/Y, W/H and colour from the code.
  - Else code 7–15 → HOLD, with `doneDrawing` pulsed in the next cycle and no pixels emitted.
- ERASE:
  - Raster order: X fastest, X 0..SCREEN_W-1, then Y 0..SCREEN_H-1.
  - Colour is 3'b000.
  - The last pixel (159,119) coincides with `doneErasing`=1; then → HOLD.
- DRAW:
  - Offsets sweep (0,0)..(W-1,H-1), X fastest.
  - `vgaX` = baseX+dx and `vgaY` = baseY+dy, truncated to 8 and 7 bits.
  - The last pixel coincides with `doneDrawing`=1; then → HOLD.
- Colours: player 3'b010, enemy 3'b100, bullet 3'b110.
  - A dead enemy (`enemyAlive` bit 0) is swept in full with colour 3'b000, so done timing is unchanged.
- HOLD: wait until `objectToDraw`==0 and `inEraseState`==0, then → IDLE. This prevents re-triggering on a code that is held one extra cycle.
- Abort:
  - In DRAW, `objectToDraw`==0 → IDLE immediately. `pixelValid` is 0 from the next cycle and no done pulse is issued.
  - In ERASE, `inEraseState` low → IDLE immediately, same rules.
  - A different non-zero code arriving mid-DRAW is ignored; the sweep continues on the latched object.
- Position inputs are sampled only on entry to DRAW.

## Timing
- Reset values:
  - State IDLE, counters 0.
  - `vgaX`=0, `vgaY`=0, `vgaColour`=0.
  - `pixelValid`=0, `doneDrawing`=0, `doneErasing`=0.
- All outputs are registered.
- Request sampled at edge *T*:
  - First pixel is presented in cycle *T*+1.
  - A W×H sprite ends at cycle *T*+W·H.
  - A full erase ends at *T*+19200.
- Done pulses last exactly one cycle and are never asserted together.
- `pixelValid` is 0 in IDLE and HOLD, and during the no-op cycle for codes 7–15.

## Configuration
- `RASTER_CLIP_EN` defined:
  - During DRAW, `pixelValid` is 0 for any pixel whose untruncated baseX+dx ≥ SCREEN_W or baseY+dy ≥ SCREEN_H.
  - Sweep length and done timing are unchanged.
- Undefined: every swept pixel is valid, and truncated coordinates wrap.

## Structure
- Package `game_pkg` holds:
  - object code constants (OBJ_NONE, OBJ_PLAYER, OBJ_ENEMY1..4, OBJ_BULLET);
  - SCREEN_W and SCREEN_H;
  - the colour constants.
- Sub-module `sweep_counter_2d` provides:
  - inputs: width, height, start, enable;
  - outputs: dx, dy and a `last` flag asserted on (W-1,H-1).
  - The block instantiates it once and shares it between ERASE and DRAW.

## Test plan
- Reset mid-erase, then deassert → all outputs 0 and state IDLE; no done pulse.
- Code 1 held with player at (20,100) → 48 valid pixels, (20,100)..(27,105), colour 3'b010; `doneDrawing` on the 48th pixel (cycle *T*+48); then HOLD until the code returns to 0.
- `inEraseState`=1 together with code 2 → erase wins: 19200 black pixels, `doneErasing` at *T*+19200, `doneDrawing` never asserted.
- Code 3 with `enemyAlive`=4'b1101 → 80 pixels at enemy2's X/Y, colour 3'b000, `doneDrawing` at *T*+80.
- Bullet at (159,118) with `RASTER_CLIP_EN` → only (159,118) and (159,119) valid out of 8 swept pixels; done still at *T*+8.
- Code 9 → no valid pixels, `doneDrawing` at *T*+1. Separately, code dropped to 0 mid-sweep → IDLE, no done pulse.

Source files
------------

// File: rtl/object_rasterizer_pkg.sv
// Shared definitions for the object rasterizer: object select codes,
// screen size, sprite colours and the rasterizer state encoding.
package game_pkg;

  localparam logic [3:0] OBJ_NONE   = 4'd0;
  localparam logic [3:0] OBJ_PLAYER = 4'd1;
  localparam logic [3:0] OBJ_ENEMY1 = 4'd2;
  localparam logic [3:0] OBJ_ENEMY2 = 4'd3;
  localparam logic [3:0] OBJ_ENEMY3 = 4'd4;
  localparam logic [3:0] OBJ_ENEMY4 = 4'd5;
  localparam logic [3:0] OBJ_BULLET = 4'd6;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_PLAYER = 3'b010;
  localparam logic [2:0] COL_ENEMY  = 3'b100;
  localparam logic [2:0] COL_BULLET = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_HOLD
  } rast_state_t;

endpackage

// File: rtl/object_rasterizer_if.sv
// Sequencer <-> rasterizer bus: object request and positions in,
// VGA pixel stream and done handshakes out.
interface object_rasterizer_if;
  logic [3:0]  objectToDraw;
  logic        inEraseState;
  logic [7:0]  playerX;
  logic [6:0]  playerY;
  logic [7:0]  bulletX;
  logic [6:0]  bulletY;
  logic [31:0] enemyX;
  logic [27:0] enemyY;
  logic [3:0]  enemyAlive;
  logic [7:0]  vgaX;
  logic [6:0]  vgaY;
  logic [2:0]  vgaColour;
  logic        pixelValid;
  logic        doneDrawing;
  logic        doneErasing;

  modport master (
    output objectToDraw, inEraseState, playerX, playerY, bulletX, bulletY,
           enemyX, enemyY, enemyAlive,
    input  vgaX, vgaY, vgaColour, pixelValid, doneDrawing, doneErasing
  );

  modport slave (
    input  objectToDraw, inEraseState, playerX, playerY, bulletX, bulletY,
           enemyX, enemyY, enemyAlive,
    output vgaX, vgaY, vgaColour, pixelValid, doneDrawing, doneErasing
  );
endinterface

// File: rtl/object_rasterizer_sweep_counter_2d.sv
// Two-dimensional raster counter, X fastest. dx/dy hold the offset of the
// next pixel to emit; last flags the final offset (W-1,H-1).
module sweep_counter_2d (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] width,
  input  logic [6:0] height,
  input  logic       start,
  input  logic       enable,
  output logic [7:0] dx,
  output logic [6:0] dy,
  output logic       last
);
  logic x_end;
  logic y_end;

  assign x_end = (dx == width - 8'd1);
  assign y_end = (dy == height - 7'd1);
  assign last  = x_end && y_end;

  // offset register: start rewinds to the origin, enable steps one pixel
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dx <= '0;
      dy <= '0;
    end else if (start) begin
      dx <= '0;
      dy <= '0;
    end else if (enable) begin
      if (x_end) begin
        dx <= '0;
        dy <= y_end ? 7'd0 : dy + 7'd1;
      end else begin
        dx <= dx + 8'd1;
      end
    end
  end
endmodule

// File: rtl/object_rasterizer.sv
// Object rasterizer: sweeps a sprite bounding box or the full screen one
// pixel per clock and returns done handshakes to the draw sequencer.
// Optional feature macro: RASTER_CLIP_EN (suppress off-screen sprite pixels).
//
// state | meaning
// IDLE  | waiting for an erase request or object code
// ERASE | sweeping the full screen in black
// DRAW  | sweeping the latched sprite box
// HOLD  | sweep done, waiting for the request to drop to zero
module object_rasterizer
  import game_pkg::*;
#(
  parameter int SCREEN_W = game_pkg::SCREEN_W,
  parameter int SCREEN_H = game_pkg::SCREEN_H,
  parameter int PLAYER_W = 8,
  parameter int PLAYER_H = 6,
  parameter int ENEMY_W  = 10,
  parameter int ENEMY_H  = 8,
  parameter int BULLET_W = 2,
  parameter int BULLET_H = 4
) (
  input logic                clk,
  input logic                resetn,
  object_rasterizer_if.slave bus
);
  rast_state_t state, state_n;

  logic [7:0] base_x_q, base_x, dec_x, pix_x, x_q, x_d;
  logic [6:0] base_y_q, base_y, dec_y, pix_y, y_q, y_d;
  logic [7:0] w_q, dec_w, cnt_w, dx;
  logic [6:0] h_q, dec_h, cnt_h, dy;
  logic [2:0] col_q, dec_col, colour_q, col_d;
  logic [1:0] eidx;
  logic       req_draw, erase_src, draw_ok, latch;
  logic       cnt_start, cnt_en, cnt_last;
  logic       valid_q, valid_d, dd_q, dd_d, de_q, de_d;

  assign eidx     = 2'(bus.objectToDraw - OBJ_ENEMY1);
  assign req_draw = (bus.objectToDraw >= OBJ_PLAYER) && (bus.objectToDraw <= OBJ_BULLET);

  // decode size, position and colour of the requested object
  always_comb begin
    dec_x   = '0;
    dec_y   = '0;
    dec_w   = '0;
    dec_h   = '0;
    dec_col = COL_BLACK;
    case (bus.objectToDraw)
      OBJ_PLAYER: begin
        dec_x = bus.playerX; dec_y = bus.playerY;
        dec_w = 8'(PLAYER_W); dec_h = 7'(PLAYER_H);
        dec_col = COL_PLAYER;
      end
      OBJ_ENEMY1, OBJ_ENEMY2, OBJ_ENEMY3, OBJ_ENEMY4: begin
        dec_x = bus.enemyX[eidx*8 +: 8];
        dec_y = bus.enemyY[eidx*7 +: 7];
        dec_w = 8'(ENEMY_W); dec_h = 7'(ENEMY_H);
        // a dead enemy is still swept so done timing does not depend on it
        dec_col = bus.enemyAlive[eidx] ? COL_ENEMY : COL_BLACK;
      end
      OBJ_BULLET: begin
        dec_x = bus.bulletX; dec_y = bus.bulletY;
        dec_w = 8'(BULLET_W); dec_h = 7'(BULLET_H);
        dec_col = COL_BULLET;
      end
      default: ;
    endcase
  end

  // in IDLE the first pixel is emitted from the live inputs, later from latches
  assign erase_src = (state == ST_ERASE) || ((state == ST_IDLE) && bus.inEraseState);

  // pick the box size and origin the shared counter and adder work on
  always_comb begin
    cnt_w  = w_q;
    cnt_h  = h_q;
    base_x = base_x_q;
    base_y = base_y_q;
    if (erase_src) begin
      cnt_w  = 8'(SCREEN_W);
      cnt_h  = 7'(SCREEN_H);
      base_x = '0;
      base_y = '0;
    end else if (state == ST_IDLE) begin
      cnt_w  = dec_w;
      cnt_h  = dec_h;
      base_x = dec_x;
      base_y = dec_y;
    end
  end

  assign pix_x = base_x + dx;
  assign pix_y = base_y + dy;

`ifdef RASTER_CLIP_EN
  logic [8:0] ux;
  logic [7:0] uy;
  assign ux      = {1'b0, base_x} + {1'b0, dx};
  assign uy      = {1'b0, base_y} + {1'b0, dy};
  assign draw_ok = (ux < 9'(SCREEN_W)) && (uy < 8'(SCREEN_H));
`else
  assign draw_ok = 1'b1;
`endif

  sweep_counter_2d u_sweep (
    .clk    (clk),
    .resetn (resetn),
    .width  (cnt_w),
    .height (cnt_h),
    .start  (cnt_start),
    .enable (cnt_en),
    .dx     (dx),
    .dy     (dy),
    .last   (cnt_last)
  );

  // next state and next registered outputs
  always_comb begin
    state_n   = state;
    cnt_start = 1'b0;
    cnt_en    = 1'b0;
    latch     = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    col_d     = colour_q;
    valid_d   = 1'b0;
    dd_d      = 1'b0;
    de_d      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_start = 1'b1;
        if (bus.inEraseState) begin
          cnt_start = 1'b0;
          cnt_en    = 1'b1;
          x_d = pix_x; y_d = pix_y; col_d = COL_BLACK;
          valid_d = 1'b1;
          de_d    = cnt_last;
          state_n = cnt_last ? ST_HOLD : ST_ERASE;
        end else if (req_draw) begin
          cnt_start = 1'b0;
          cnt_en    = 1'b1;
          latch     = 1'b1;
          x_d = pix_x; y_d = pix_y; col_d = dec_col;
          valid_d = draw_ok;
          dd_d    = cnt_last;
          state_n = cnt_last ? ST_HOLD : ST_DRAW;
        end else if (bus.objectToDraw != OBJ_NONE) begin
          dd_d    = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_ERASE: begin
        if (!bus.inEraseState) begin
          cnt_start = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
          x_d = pix_x; y_d = pix_y; col_d = COL_BLACK;
          valid_d = 1'b1;
          de_d    = cnt_last;
          if (cnt_last) state_n = ST_HOLD;
        end
      end
      ST_DRAW: begin
        if (bus.objectToDraw == OBJ_NONE) begin
          cnt_start = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
          x_d = pix_x; y_d = pix_y; col_d = col_q;
          valid_d = draw_ok;
          dd_d    = cnt_last;
          if (cnt_last) state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        cnt_start = 1'b1;
        if ((bus.objectToDraw == OBJ_NONE) && !bus.inEraseState) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  // sprite latches and registered pixel outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      base_x_q <= '0; base_y_q <= '0;
      w_q      <= '0; h_q      <= '0;
      col_q    <= '0;
      x_q      <= '0; y_q      <= '0;
      colour_q <= '0;
      valid_q  <= 1'b0;
      dd_q     <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      if (latch) begin
        base_x_q <= dec_x; base_y_q <= dec_y;
        w_q      <= dec_w; h_q      <= dec_h;
        col_q    <= dec_col;
      end
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= col_d;
      valid_q  <= valid_d;
      dd_q     <= dd_d;
      de_q     <= de_d;
    end
  end

  assign bus.vgaX        = x_q;
  assign bus.vgaY        = y_q;
  assign bus.vgaColour   = colour_q;
  assign bus.pixelValid  = valid_q;
  assign bus.doneDrawing = dd_q;
  assign bus.doneErasing = de_q;
endmodule

// File: tb/tb_object_rasterizer.sv
// Directed bench for object_rasterizer; honours RASTER_CLIP_EN if defined.
module tb_object_rasterizer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int tests = 0;
  int fails = 0;

  object_rasterizer_if bus ();

  object_rasterizer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_valid"}, i, bus.pixelValid, 0);
      chk({tag, "_dd"}, i, bus.doneDrawing, 0);
      chk({tag, "_de"}, i, bus.doneErasing, 0);
    end
  endtask

  // caller has just applied the request; checks every swept pixel then HOLD
  task automatic run_sprite(input string tag, input int w, input int h, input int bx,
                            input int by, input int col);
    int ux, uy, ev;
    for (int i = 0; i < w * h; i++) begin
      step();
      ux = bx + i % w;
      uy = by + i / w;
      ev = 1;
`ifdef RASTER_CLIP_EN
      ev = (ux < 160 && uy < 120) ? 1 : 0;
`endif
      chk({tag, "_valid"}, i, bus.pixelValid, ev);
      chk({tag, "_x"}, i, bus.vgaX, ux & 255);
      chk({tag, "_y"}, i, bus.vgaY, uy & 127);
      chk({tag, "_col"}, i, bus.vgaColour, col);
      chk({tag, "_dd"}, i, bus.doneDrawing, (i == w * h - 1) ? 1 : 0);
      chk({tag, "_de"}, i, bus.doneErasing, 0);
    end
    quiet({tag, "_hold"}, 3);
  endtask

  task automatic release_all();
    bus.objectToDraw = 4'd0;
    bus.inEraseState = 1'b0;
    step();
    step();
  endtask

  initial begin
    bus.objectToDraw = 4'd0;
    bus.inEraseState = 1'b0;
    bus.playerX = 8'd20;  bus.playerY = 7'd100;
    bus.bulletX = 8'd159; bus.bulletY = 7'd118;
    bus.enemyX = {8'd140, 8'd90, 8'd50, 8'd10};
    bus.enemyY = {7'd112, 7'd60, 7'd30, 7'd5};
    bus.enemyAlive = 4'b1101;

    // reset values
    step(); step(); step();
    chk("rst_x", 0, bus.vgaX, 0);
    chk("rst_y", 0, bus.vgaY, 0);
    chk("rst_col", 0, bus.vgaColour, 0);
    chk("rst_valid", 0, bus.pixelValid, 0);
    chk("rst_dd", 0, bus.doneDrawing, 0);
    chk("rst_de", 0, bus.doneErasing, 0);

    // reset in the middle of an erase
    resetn = 1'b1;
    bus.inEraseState = 1'b1;
    for (int i = 0; i < 30; i++) step();
    chk("pre_rst_valid", 0, bus.pixelValid, 1);
    chk("pre_rst_x", 0, bus.vgaX, 29);
    resetn = 1'b0;
    bus.inEraseState = 1'b0;
    step();
    resetn = 1'b1;
    chk("mid_rst_x", 0, bus.vgaX, 0);
    chk("mid_rst_y", 0, bus.vgaY, 0);
    chk("mid_rst_col", 0, bus.vgaColour, 0);
    chk("mid_rst_valid", 0, bus.pixelValid, 0);
    quiet("post_rst", 3);

    // player at (20,100)
    bus.objectToDraw = 4'd1;
    run_sprite("player", 8, 6, 20, 100, 2);
    release_all();

    // erase wins over a simultaneous code
    bus.inEraseState = 1'b1;
    bus.objectToDraw = 4'd2;
    for (int i = 0; i < 19200; i++) begin
      step();
      chk("erase_valid", i, bus.pixelValid, 1);
      chk("erase_x", i, bus.vgaX, i % 160);
      chk("erase_y", i, bus.vgaY, i / 160);
      chk("erase_col", i, bus.vgaColour, 0);
      chk("erase_de", i, bus.doneErasing, (i == 19199) ? 1 : 0);
      chk("erase_dd", i, bus.doneDrawing, 0);
    end
    quiet("erase_hold", 3);
    release_all();

    // dead enemy2 drawn black, then live enemy4
    bus.objectToDraw = 4'd3;
    run_sprite("enemy2_dead", 10, 8, 50, 30, 0);
    release_all();
    bus.objectToDraw = 4'd5;
    run_sprite("enemy4", 10, 8, 140, 112, 4);
    release_all();

    // bullet at the screen corner, then player wrapping past both edges
    bus.objectToDraw = 4'd6;
    run_sprite("bullet_edge", 2, 4, 159, 118, 6);
    release_all();
    bus.playerX = 8'd250; bus.playerY = 7'd125;
    bus.objectToDraw = 4'd1;
    run_sprite("player_wrap", 8, 6, 250, 125, 2);
    release_all();

    // undefined code: no pixels, done in the next cycle, then HOLD
    bus.objectToDraw = 4'd9;
    step();
    chk("code9_valid", 0, bus.pixelValid, 0);
    chk("code9_dd", 0, bus.doneDrawing, 1);
    chk("code9_de", 0, bus.doneErasing, 0);
    quiet("code9_hold", 3);
    release_all();

    // code switch mid-draw is ignored, then drop to zero aborts
    bus.playerX = 8'd20; bus.playerY = 7'd100;
    bus.objectToDraw = 4'd1;
    for (int i = 0; i < 5; i++) step();
    bus.objectToDraw = 4'd6;
    step();
    chk("switch_x", 0, bus.vgaX, 25);
    chk("switch_col", 0, bus.vgaColour, 2);
    chk("switch_valid", 0, bus.pixelValid, 1);
    for (int i = 0; i < 4; i++) step();
    chk("switch_x", 1, bus.vgaX, 21);
    chk("switch_y", 1, bus.vgaY, 101);
    bus.objectToDraw = 4'd0;
    quiet("draw_abort", 4);

    // back in IDLE: a fresh request starts at once
    bus.bulletX = 8'd10; bus.bulletY = 7'd10;
    bus.objectToDraw = 4'd6;
    run_sprite("bullet", 2, 4, 10, 10, 6);
    release_all();

    // erase abort
    bus.inEraseState = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("erase_ab_valid", 0, bus.pixelValid, 1);
    bus.inEraseState = 1'b0;
    quiet("erase_abort", 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
